ctrl_fsm: RTL and testbench
===========================

CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameter: DWIDTH, 16, instruction and data word width.
REQ-002 Parameter: TIMEOUT, 15, maximum cycles spent in WAIT_ALU before entering ERR.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  launches execution from IDLE or ERR.
REQ-006 ir_req / ir_ack / ir_data  out 1 / in 1 / in DWIDTH  instruction fetch handshake and fetched word.
REQ-007 mem_req / mem_we / mem_addr / mem_ack  out 1 / out 1 / out 8 / in 1  data-memory handshake; mem_we=1 means store.
REQ-008 dp_done  in  1  datapath ALU result-valid pulse.
REQ-009 en_in, en_pc_pulse, alu_in_sel, ldr_sel  out  1 each  datapath strobes and selects.
REQ-010 pc_ctrl  out  2  00 hold, 01 increment, 10 load offset_addr; 11 is never driven.
REQ-011 rd, rs  out  2 each; reg_en  out  4; alu_func  out  3; offset_addr, offset  out  8 each.
REQ-012 busy, halted, err  out  1 each  status flags.

Function
REQ-013 IR field layout: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
REQ-014 rd, rs, offset, offset_addr and mem_addr SHALL be driven from the latched IR and held stable from DECODE through PC_UPD.
REQ-015 Opcode map: 0 NOP; 1 ADD (000); 2 SUB (001); 3 AND (010); 4 OR (011); 5 XOR (100); 6 ADDI (alu_func 000, alu_in_sel=1); 8 LDR rd<=mem[imm]; 9 STR mem[imm]<=rs; A JMP imm; F HALT; all other opcodes are illegal. Values in parentheses are alu_func.
REQ-016 States: IDLE, FETCH, DECODE, EXEC, WAIT_ALU, WB, MEM, PC_UPD, HALT, ERR.
REQ-017 IDLE: go to FETCH on start=1; busy=0.
REQ-018 FETCH: hold ir_req=1 until ir_ack=1; latch ir_data on the ack cycle; go to DECODE. ir_ack while ir_req=0 SHALL be ignored.
REQ-019 DECODE (1 cycle) transitions:
- ALU ops -> EXEC.
- LDR/STR -> MEM.
- NOP/JMP -> PC_UPD.
- HALT -> HALT.
- Illegal opcode -> ERR.
REQ-020 EXEC (1 cycle): en_in=1, reg_en=0000; go to WAIT_ALU.
REQ-021 WAIT_ALU: wait for dp_done=1, then go to WB. Reaching TIMEOUT cycles without dp_done SHALL go to ERR.
REQ-022 WB (1 cycle): en_in=1, ldr_sel=0, reg_en=one-hot(rd) (rd=2 -> 0100); go to PC_UPD.
REQ-023 MEM: hold mem_req=1 and mem_we=(STR) until mem_ack.
- LDR: on the ack cycle, en_in=1, ldr_sel=1, reg_en=one-hot(rd).
- STR: no register write.
- Both: go to PC_UPD.
REQ-024 PC_UPD (1 cycle): en_pc_pulse=1; pc_ctrl=10 with offset_addr=imm for JMP, otherwise 01; go to FETCH.
REQ-025 Outside the cycles named above, en_in, en_pc_pulse, reg_en, ldr_sel, ir_req and mem_req SHALL be 0 and pc_ctrl=00.
REQ-026 HALT: halted=1; remain until reset; start is ignored.
REQ-027 ERR: err=1; start=1 clears err and goes to IDLE.
REQ-028 busy=1 in every state except IDLE, HALT and ERR. start while busy is ignored.
REQ-029 Latency for an ALU op with dp_done k cycles after EXEC: FETCH-ack to next ir_req = k+4 cycles.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, IR=0 and every output to 0, including mid-handshake.
REQ-031 Reset SHALL win over any simultaneous ack, dp_done or start.
REQ-032 After release, no request is issued until start.

Verification
REQ-033 ADD: start, ir_data=0x1600, dp_done 3 cycles after EXEC -> EXEC en_in pulse, WB reg_en=0010 with alu_func=000, then en_pc_pulse with pc_ctrl=01.
REQ-034 LDR: ir_data=0x8C42, mem_ack after 2 cycles -> mem_addr=0x42, mem_we=0; ack cycle has ldr_sel=1, reg_en=1000, en_in=1.
REQ-035 JMP: ir_data=0xA07F -> no en_in; PC_UPD drives pc_ctrl=10, offset_addr=0x7F.
REQ-036 Timeout: ADD with dp_done never asserted -> err=1 after 15 WAIT_ALU cycles; start then returns to IDLE with err=0.
REQ-037 Illegal opcode 0x7000 -> ERR, with no en_in and no en_pc_pulse. HALT 0xF000 -> halted=1, and start is ignored.
REQ-038 Reset mid-MEM (mem_req=1): assert rst_n=0 -> all outputs 0 in the same cycle; after release, outputs stay idle until start.

Source files
------------

// File: rtl/ctrl_fsm_if.sv
// Handshake and strobe bundle between the instruction controller and its datapath/memory.
// master is the controller side; slave is the datapath/memory/stimulus side.
interface ctrl_fsm_if #(
  parameter int unsigned DWIDTH = 16
);
  logic              start;
  logic              ir_req;
  logic              ir_ack;
  logic [DWIDTH-1:0] ir_data;
  logic              mem_req;
  logic              mem_we;
  logic [7:0]        mem_addr;
  logic              mem_ack;
  logic              dp_done;
  logic              en_in;
  logic              en_pc_pulse;
  logic              alu_in_sel;
  logic              ldr_sel;
  logic [1:0]        pc_ctrl;
  logic [1:0]        rd;
  logic [1:0]        rs;
  logic [3:0]        reg_en;
  logic [2:0]        alu_func;
  logic [7:0]        offset_addr;
  logic [7:0]        offset;
  logic              busy;
  logic              halted;
  logic              err;

  modport master (
    input  start, ir_ack, ir_data, mem_ack, dp_done,
    output ir_req, mem_req, mem_we, mem_addr, en_in, en_pc_pulse, alu_in_sel, ldr_sel,
           pc_ctrl, rd, rs, reg_en, alu_func, offset_addr, offset, busy, halted, err
  );

  modport slave (
    output start, ir_ack, ir_data, mem_ack, dp_done,
    input  ir_req, mem_req, mem_we, mem_addr, en_in, en_pc_pulse, alu_in_sel, ldr_sel,
           pc_ctrl, rd, rs, reg_en, alu_func, offset_addr, offset, busy, halted, err
  );
endinterface

// File: rtl/ctrl_fsm.sv
// Instruction-sequencing controller: fetches one word, decodes it and walks it through the
// ALU, memory and PC-update strobes before fetching the next.
module ctrl_fsm #(
  parameter int unsigned DWIDTH  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input logic        clk,
  input logic        rst_n,
  ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWaitAlu,
    StWb,
    StMem,
    StPcUpd,
    StHalt,
    StErr
  } state_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpSub  = 4'h2;
  localparam logic [3:0] OpAnd  = 4'h3;
  localparam logic [3:0] OpOr   = 4'h4;
  localparam logic [3:0] OpXor  = 4'h5;
  localparam logic [3:0] OpAddi = 4'h6;
  localparam logic [3:0] OpLdr  = 4'h8;
  localparam logic [3:0] OpStr  = 4'h9;
  localparam logic [3:0] OpJmp  = 4'hA;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam int unsigned   CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;

  logic       en_in_q, en_in_d;
  logic       en_pc_q, en_pc_d;
  logic       ir_req_q, ir_req_d;
  logic       mem_req_q, mem_req_d;
  logic       mem_we_q, mem_we_d;
  logic [1:0] pc_ctrl_q, pc_ctrl_d;
  logic [3:0] reg_en_q, reg_en_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;
  logic       err_q, err_d;

  logic       ldr_wr;
  logic [2:0] alu_func;

  assign op_q = ir_q[15:12];
  assign op_d = ir_d[15:12];

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = StFetch;
      StFetch: begin
        if (bus.ir_ack) begin
          ir_d    = bus.ir_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (op_q inside {OpAdd, OpSub, OpAnd, OpOr, OpXor, OpAddi}) state_d = StExec;
        else if (op_q inside {OpLdr, OpStr})                        state_d = StMem;
        else if (op_q inside {OpNop, OpJmp})                        state_d = StPcUpd;
        else if (op_q == OpHalt)                                    state_d = StHalt;
        else                                                        state_d = StErr;
      end
      StExec: begin
        cnt_d   = '0;
        state_d = StWaitAlu;
      end
      StWaitAlu: begin
        // dp_done on the final allowed cycle still counts as a completion
        if (bus.dp_done)            state_d = StWb;
        else if (cnt_q == CntLast)  state_d = StErr;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      StWb:     state_d = StPcUpd;
      StMem:    if (bus.mem_ack) state_d = StPcUpd;
      StPcUpd:  state_d = StFetch;
      StHalt:   state_d = StHalt;
      StErr:    if (bus.start) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the state being entered so they come straight off flops.
  always_comb begin
    en_in_d   = (state_d == StExec) || (state_d == StWb);
    en_pc_d   = (state_d == StPcUpd);
    pc_ctrl_d = 2'b00;
    if (state_d == StPcUpd) pc_ctrl_d = (op_d == OpJmp) ? 2'b10 : 2'b01;
    reg_en_d  = (state_d == StWb) ? (4'b0001 << ir_d[11:10]) : 4'b0000;
    ir_req_d  = (state_d == StFetch);
    mem_req_d = (state_d == StMem);
    mem_we_d  = (state_d == StMem) && (op_d == OpStr);
    busy_d    = !(state_d inside {StIdle, StHalt, StErr});
    halted_d  = (state_d == StHalt);
    err_d     = (state_d == StErr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      cnt_q     <= '0;
      en_in_q   <= 1'b0;
      en_pc_q   <= 1'b0;
      ir_req_q  <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      pc_ctrl_q <= 2'b00;
      reg_en_q  <= 4'b0000;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      en_in_q   <= en_in_d;
      en_pc_q   <= en_pc_d;
      ir_req_q  <= ir_req_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      pc_ctrl_q <= pc_ctrl_d;
      reg_en_q  <= reg_en_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
    end
  end

  // A load writes back in the very cycle memory acknowledges, so this term bypasses the flops.
  assign ldr_wr = (state_q == StMem) && bus.mem_ack && (op_q == OpLdr);

  always_comb begin
    alu_func = 3'b000;
    case (op_q)
      OpSub:   alu_func = 3'b001;
      OpAnd:   alu_func = 3'b010;
      OpOr:    alu_func = 3'b011;
      OpXor:   alu_func = 3'b100;
      default: alu_func = 3'b000;
    endcase
  end

  assign bus.ir_req      = ir_req_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = ir_q[7:0];
  assign bus.en_in       = en_in_q | ldr_wr;
  assign bus.en_pc_pulse = en_pc_q;
  assign bus.alu_in_sel  = (op_q == OpAddi);
  assign bus.ldr_sel     = ldr_wr;
  assign bus.pc_ctrl     = pc_ctrl_q;
  assign bus.rd          = ir_q[11:10];
  assign bus.rs          = ir_q[9:8];
  assign bus.reg_en      = reg_en_q | (ldr_wr ? (4'b0001 << ir_q[11:10]) : 4'b0000);
  assign bus.alu_func    = alu_func;
  assign bus.offset_addr = ir_q[7:0];
  assign bus.offset      = ir_q[7:0];
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: a cycle-by-cycle vector table for the main instruction mix,
// plus hand sequences for ALU latency, the WAIT_ALU timeout and reset during a memory access.
module tb_ctrl_fsm;
  localparam int unsigned DWIDTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_fsm_if #(.DWIDTH(DWIDTH)) bus ();

  ctrl_fsm #(.DWIDTH(DWIDTH), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       en_in;
    logic       en_pc;
    logic       ldr_sel;
    logic       ir_req;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] pc_ctrl;
    logic [3:0] reg_en;
    logic       busy;
    logic       halted;
    logic       err;
    logic [7:0] mem_addr;
    logic [7:0] offset_addr;
  } outs_t;

  typedef struct {
    string       name;
    logic        start;
    logic        ir_ack;
    logic [15:0] ir_data;
    logic        mem_ack;
    logic        dp_done;
    outs_t       exp;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic outs_t mk(input logic en_in, input logic en_pc, input logic ldr,
                               input logic irq, input logic mrq, input logic we,
                               input logic [1:0] pc, input logic [3:0] re, input logic b,
                               input logic h, input logic e, input logic [7:0] a);
    outs_t o;
    o.en_in = en_in; o.en_pc = en_pc; o.ldr_sel = ldr; o.ir_req = irq; o.mem_req = mrq;
    o.mem_we = we; o.pc_ctrl = pc; o.reg_en = re; o.busy = b; o.halted = h; o.err = e;
    o.mem_addr = a; o.offset_addr = a;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t s;
    s.en_in = bus.en_in; s.en_pc = bus.en_pc_pulse; s.ldr_sel = bus.ldr_sel;
    s.ir_req = bus.ir_req; s.mem_req = bus.mem_req; s.mem_we = bus.mem_we;
    s.pc_ctrl = bus.pc_ctrl; s.reg_en = bus.reg_en; s.busy = bus.busy;
    s.halted = bus.halted; s.err = bus.err; s.mem_addr = bus.mem_addr;
    s.offset_addr = bus.offset_addr;
    return s;
  endfunction

  task automatic add(input string nm, input logic s, input logic a, input logic [15:0] d,
                     input logic m, input logic dn, input outs_t ex);
    vec_t v;
    v.name = nm; v.start = s; v.ir_ack = a; v.ir_data = d; v.mem_ack = m; v.dp_done = dn;
    v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, got, want);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic s, input logic a, input logic [15:0] d, input logic m,
                       input logic dn);
    @(negedge clk);
    bus.start = s; bus.ir_ack = a; bus.ir_data = d; bus.mem_ack = m; bus.dp_done = dn;
    #1;
  endtask

  task automatic alu_run(input string nm, input logic [15:0] ir, input int k,
                         input logic [2:0] func, input logic insel);
    logic [3:0] oh;
    int         n;
    case (ir[11:10])
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      default: oh = 4'b1000;
    endcase
    drive(1'b0, 1'b1, ir, 1'b0, 1'b0);
    chk({nm, "_fetch"}, 64'(bus.ir_req), 64'(1'b1));
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk({nm, "_exec"}, 64'({bus.en_in, bus.reg_en}), 64'({1'b1, 4'b0000}));
    for (int j = 1; j <= k; j++) drive(1'b0, 1'b0, 16'h0, 1'b0, (j == k));
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk({nm, "_wb"},
        64'({bus.en_in, bus.ldr_sel, bus.reg_en, bus.alu_func, bus.alu_in_sel, bus.rd, bus.rs}),
        64'({1'b1, 1'b0, oh, func, insel, ir[11:10], ir[9:8]}));
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk({nm, "_pcupd"}, 64'({bus.en_pc_pulse, bus.pc_ctrl, bus.en_in}),
        64'({1'b1, 2'b01, 1'b0}));
    n = k + 4;
    for (int j = 0; j < 10; j++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      n++;
      if (bus.ir_req) break;
    end
    // Clock edges from the one that takes the ack to the one that raises the next ir_req.
    chk({nm, "_latency"}, 64'(n - 1), 64'(k + 4));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100 us");
    $fatal(1);
  end

  initial begin
    //   name               st ack data     mack done  exp(en_in,en_pc,ldr,irq,mrq,we,pc,reg_en,busy,halt,err,addr)
    add("idle",            0, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,0,0,0,8'h00));
    add("idle_start",      1, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,0,0,0,8'h00));
    add("add_fetch_wait",  0, 0, 16'h0000, 0, 0, mk(0,0,0,1,0,0,2'b00,4'b0000,1,0,0,8'h00));
    add("add_fetch_ack",   0, 1, 16'h1600, 0, 0, mk(0,0,0,1,0,0,2'b00,4'b0000,1,0,0,8'h00));
    add("add_decode",      1, 1, 16'hFFFF, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,1,0,0,8'h00));
    add("add_exec",        0, 0, 16'h0000, 0, 0, mk(1,0,0,0,0,0,2'b00,4'b0000,1,0,0,8'h00));
    add("add_wait1",       0, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,1,0,0,8'h00));
    add("add_wait2",       0, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,1,0,0,8'h00));
    add("add_done",        0, 0, 16'h0000, 0, 1, mk(0,0,0,0,0,0,2'b00,4'b0000,1,0,0,8'h00));
    add("add_wb",          0, 0, 16'h0000, 0, 0, mk(1,0,0,0,0,0,2'b00,4'b0010,1,0,0,8'h00));
    add("add_pcupd",       0, 0, 16'h0000, 0, 0, mk(0,1,0,0,0,0,2'b01,4'b0000,1,0,0,8'h00));
    add("ldr_fetch_ack",   0, 1, 16'h8C42, 0, 0, mk(0,0,0,1,0,0,2'b00,4'b0000,1,0,0,8'h00));
    add("ldr_decode",      0, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,1,0,0,8'h42));
    add("ldr_mem1",        0, 0, 16'h0000, 0, 0, mk(0,0,0,0,1,0,2'b00,4'b0000,1,0,0,8'h42));
    add("ldr_mem2",        0, 0, 16'h0000, 0, 0, mk(0,0,0,0,1,0,2'b00,4'b0000,1,0,0,8'h42));
    add("ldr_mem_ack",     0, 0, 16'h0000, 1, 0, mk(1,0,1,0,1,0,2'b00,4'b1000,1,0,0,8'h42));
    add("ldr_pcupd",       0, 0, 16'h0000, 0, 0, mk(0,1,0,0,0,0,2'b01,4'b0000,1,0,0,8'h42));
    add("str_fetch_ack",   0, 1, 16'h9533, 0, 0, mk(0,0,0,1,0,0,2'b00,4'b0000,1,0,0,8'h42));
    add("str_decode",      0, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,1,0,0,8'h33));
    add("str_mem_ack",     0, 0, 16'h0000, 1, 0, mk(0,0,0,0,1,1,2'b00,4'b0000,1,0,0,8'h33));
    add("str_pcupd",       0, 0, 16'h0000, 0, 0, mk(0,1,0,0,0,0,2'b01,4'b0000,1,0,0,8'h33));
    add("jmp_fetch_ack",   0, 1, 16'hA07F, 0, 0, mk(0,0,0,1,0,0,2'b00,4'b0000,1,0,0,8'h33));
    add("jmp_decode",      0, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,1,0,0,8'h7F));
    add("jmp_pcupd",       0, 0, 16'h0000, 0, 0, mk(0,1,0,0,0,0,2'b10,4'b0000,1,0,0,8'h7F));
    add("nop_fetch_ack",   0, 1, 16'h0000, 0, 0, mk(0,0,0,1,0,0,2'b00,4'b0000,1,0,0,8'h7F));
    add("nop_decode",      0, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,1,0,0,8'h00));
    add("nop_pcupd",       0, 0, 16'h0000, 0, 0, mk(0,1,0,0,0,0,2'b01,4'b0000,1,0,0,8'h00));
    add("ill_fetch_ack",   0, 1, 16'h7000, 0, 0, mk(0,0,0,1,0,0,2'b00,4'b0000,1,0,0,8'h00));
    add("ill_decode",      0, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,1,0,0,8'h00));
    add("ill_err",         0, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,0,0,1,8'h00));
    add("err_start",       1, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,0,0,1,8'h00));
    add("idle_again",      1, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,0,0,0,8'h00));
    add("halt_fetch_ack",  0, 1, 16'hF000, 0, 0, mk(0,0,0,1,0,0,2'b00,4'b0000,1,0,0,8'h00));
    add("halt_decode",     0, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,1,0,0,8'h00));
    add("halt_start",      1, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,0,1,0,8'h00));
    add("halt_hold",       0, 0, 16'h0000, 0, 0, mk(0,0,0,0,0,0,2'b00,4'b0000,0,1,0,8'h00));

    bus.start = 1'b0; bus.ir_ack = 1'b0; bus.ir_data = '0; bus.mem_ack = 1'b0;
    bus.dp_done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", 64'(sample()), 64'(0));
    chk("reset_fields", 64'({bus.rd, bus.rs, bus.alu_func, bus.alu_in_sel, bus.offset}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].ir_ack, vecs[i].ir_data, vecs[i].mem_ack, vecs[i].dp_done);
      chk(vecs[i].name, 64'(sample()), 64'(vecs[i].exp));
    end

    // Leave HALT via reset, then run ALU ops back to back with different dp_done delays.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    alu_run("add", 16'h1600, 3, 3'b000, 1'b0);
    alu_run("sub", 16'h2500, 1, 3'b001, 1'b0);
    alu_run("xor", 16'h5C00, 5, 3'b100, 1'b0);
    alu_run("addi", 16'h6B12, 2, 3'b000, 1'b1);

    // WAIT_ALU timeout: 15 quiet cycles are tolerated, the next cycle shows err.
    drive(1'b0, 1'b1, 16'h1600, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("to_exec", 64'(bus.en_in), 64'(1'b1));
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      chk($sformatf("to_wait%0d", i), 64'({bus.err, bus.busy}), 64'({1'b0, 1'b1}));
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("to_err", 64'({bus.err, bus.busy, bus.en_in, bus.en_pc_pulse}), 64'({4'b1000}));
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("to_err_start", 64'(bus.err), 64'(1'b1));
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("to_idle", 64'({bus.err, bus.busy, bus.ir_req}), 64'(0));

    // Reset in the middle of a memory handshake, with ack/done/start all asserted.
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h8C42, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("rst_pre_mem", 64'({bus.mem_req, bus.mem_addr}), 64'({1'b1, 8'h42}));
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.start = 1'b1; bus.dp_done = 1'b1; bus.ir_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_now_outs", 64'(sample()), 64'(0));
    chk("rst_now_fields", 64'({bus.rd, bus.rs, bus.alu_func, bus.alu_in_sel, bus.offset}),
        64'(0));
    @(negedge clk);
    #1;
    chk("rst_held", 64'(sample()), 64'(0));
    @(negedge clk);
    bus.mem_ack = 1'b0; bus.start = 1'b0; bus.dp_done = 1'b0; bus.ir_ack = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      chk($sformatf("rst_idle%0d", i), 64'(sample()), 64'(0));
    end
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("rst_restart", 64'({bus.ir_req, bus.busy}), 64'({1'b1, 1'b1}));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
